// File: rtl/tx_fcs_append.sv
// ---------------------------------------------------------------------------
// tx_fcs_append
//
// Purpose:
//   Byte-wide Ethernet transmit helper. It takes a frame with no FCS and passes
//   it straight through with zero latency. If the frame is shorter than
//   MIN_LEN bytes, it adds 0x00 pad bytes. It then appends the 4-byte
//   Ethernet FCS (CRC-32), sending the least-significant byte first.
//
// Parameters:
//   MIN_LEN   minimum frame length in bytes, excluding the FCS (0 = no pad)
//   CNT_W     width of the saturating payload+pad byte counter
//
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous active-high reset
//   clear      synchronous abort of the current frame (same effect as reset)
//   in_data    input frame byte
//   in_valid   in_data holds a valid byte
//   in_last    marks the final input byte of a frame (qualified by in_valid)
//   in_ready   block can accept in_data this cycle
//   out_data   outgoing byte: payload, pad or FCS
//   out_valid  out_data holds a valid byte
//   out_last   high with the final FCS byte only
//   out_ready  downstream accepts out_data this cycle
// ---------------------------------------------------------------------------
module tx_fcs_append #(
    parameter int MIN_LEN = 60,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready
);

    localparam logic [31:0]      CRC_POLY  = 32'hEDB88320;
    localparam logic [31:0]      CRC_INIT  = 32'hFFFFFFFF;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [31:0]      MIN_LEN_U = 32'(MIN_LEN);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PAD,
        FCS
    } txState_t;

    txState_t         r_state;
    txState_t         w_stateNext;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic [CNT_W-1:0] w_cntInc;
    logic [31:0]      r_crc;
    logic [31:0]      w_crcNext;
    logic [31:0]      w_fcs;
    logic [1:0]       r_idx;
    logic [1:0]       w_idxNext;

    // Process one byte through the reflected CRC-32 register.
    // The byte is XORed into the low bits, then the register is shifted
    // right eight times, starting with the least-significant bit.
    function automatic logic [31:0] crcByte(input logic [31:0] crc,
                                            input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // The counter stops at its maximum value instead of wrapping around.
    // This matters only for frames longer than 2^CNT_W-1 bytes.
    assign w_cntInc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    // The CRC register does not change while in FCS.
    // So its inverted value stays fixed until the last FCS byte has left.
    assign w_fcs = ~r_crc;

    // Next-state and output logic.
    // In IDLE and DATA the input is wired straight through to the output.
    // In PAD and FCS the block generates its own bytes and stalls the input.
    // Nothing advances unless an output transfer happens, so a low out_ready
    // freezes the whole block.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_crcNext   = r_crc;
        w_idxNext   = r_idx;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_data    = 8'h00;
        out_last    = 1'b0;

        case (r_state)
            IDLE, DATA: begin
                out_data  = in_data;
                out_valid = in_valid;
                in_ready  = out_ready;
                if (in_valid && out_ready) begin
                    w_cntNext = w_cntInc;
                    w_crcNext = crcByte(r_crc, in_data);
                    if (in_last) begin
                        w_stateNext = (32'(w_cntInc) < MIN_LEN_U) ? PAD : FCS;
                    end else begin
                        w_stateNext = DATA;
                    end
                end
            end

            PAD: begin
                out_valid = 1'b1;
                out_data  = 8'h00;
                if (out_ready) begin
                    w_cntNext = w_cntInc;
                    w_crcNext = crcByte(r_crc, 8'h00);
                    if (32'(w_cntInc) >= MIN_LEN_U) begin
                        w_stateNext = FCS;
                    end
                end
            end

            FCS: begin
                out_valid = 1'b1;
                out_last  = (r_idx == 2'd3);
                case (r_idx)
                    2'd0:    out_data = w_fcs[7:0];
                    2'd1:    out_data = w_fcs[15:8];
                    2'd2:    out_data = w_fcs[23:16];
                    default: out_data = w_fcs[31:24];
                endcase
                if (out_ready) begin
                    if (r_idx == 2'd3) begin
                        w_stateNext = IDLE;
                        w_idxNext   = 2'd0;
                        w_cntNext   = '0;
                        w_crcNext   = CRC_INIT;
                    end else begin
                        w_idxNext = r_idx + 2'd1;
                    end
                end
            end

            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // State register.
    // reset and clear both drop any partial frame and take priority over
    // any transfer happening in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_crc   <= CRC_INIT;
            r_idx   <= 2'd0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_crc   <= w_crcNext;
            r_idx   <= w_idxNext;
        end
    end

endmodule

// File: tb/tb_tx_fcs_append.sv
// ---------------------------------------------------------------------------
// tb_tx_fcs_append
//
// Purpose:
//   Self-checking bench for tx_fcs_append. It drives two instances from the
//   same stimulus, one with MIN_LEN=60 and one with MIN_LEN=0, and observes
//   whichever instance `sel` selects.
//
//   The expected byte stream is built at frame level: split the input into
//   frames, pad each to the minimum length, then append the table-driven
//   CRC-32 FCS, least-significant byte first.
// ---------------------------------------------------------------------------
module tb_tx_fcs_append;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b1;

    logic       padInReady, padOutValid, padOutLast;
    logic [7:0] padOutData;
    logic       rawInReady, rawOutValid, rawOutLast;
    logic [7:0] rawOutData;

    logic       sel = 1'b1;
    logic       mInReady, mOutValid, mOutLast;
    logic [7:0] mOutData;

    int checkCount = 0;
    int passCount  = 0;

    logic [31:0] crcTable[256];
    logic [7:0]  stimData[$];
    logic        stimLast[$];
    logic [8:0]  expQ[$];
    logic [8:0]  outQ[$];
    logic [7:0]  inQ[$];
    int          lastCount = 0;

    tx_fcs_append #(.MIN_LEN(60), .CNT_W(16)) dutPad (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (padInReady),
        .out_data (padOutData),
        .out_valid(padOutValid),
        .out_last (padOutLast),
        .out_ready(out_ready)
    );

    tx_fcs_append #(.MIN_LEN(0), .CNT_W(16)) dutRaw (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (rawInReady),
        .out_data (rawOutData),
        .out_valid(rawOutValid),
        .out_last (rawOutLast),
        .out_ready(out_ready)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Select which instance's outputs the monitor and checks look at.
    always_comb begin
        mInReady  = sel ? padInReady  : rawInReady;
        mOutValid = sel ? padOutValid : rawOutValid;
        mOutLast  = sel ? padOutLast  : rawOutLast;
        mOutData  = sel ? padOutData  : rawOutData;
    end

    // Monitor.
    // Inputs stay stable between the falling edge and the next rising edge,
    // so whatever is seen here is exactly what transfers on that rising edge.
    always @(negedge clk) begin
        if (!reset && !clear) begin
            if (mOutValid && out_ready) begin
                outQ.push_back({mOutLast, mOutData});
                if (mOutLast) lastCount++;
            end
            if (in_valid && mInReady) inQ.push_back(in_data);
        end
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // Advance the reference CRC by one byte using the lookup table.
    function automatic logic [31:0] crcUpdate(input logic [31:0] crc, input logic [7:0] b);
        return crcTable[(crc[7:0] ^ b)] ^ (crc >> 8);
    endfunction

    // Hold reset for two cycles with all inputs idle.
    task automatic applyReset();
        @(posedge clk); #1;
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Append one frame to the stimulus.
    // Payload bytes are random, and the last byte carries in_last.
    task automatic addRandomFrame(input int len);
        for (int i = 0; i < len; i++) begin
            stimData.push_back(8'($urandom));
            stimLast.push_back(i == len - 1);
        end
    endtask

    // Build the expected output stream from the stimulus at frame level.
    task automatic buildExpected(input int minLen);
        logic [7:0]  frame[$];
        logic [31:0] crc;
        expQ.delete();
        frame.delete();
        for (int i = 0; i < stimData.size(); i++) begin
            frame.push_back(stimData[i]);
            if (stimLast[i]) begin
                while (frame.size() < minLen) frame.push_back(8'h00);
                crc = 32'hFFFFFFFF;
                foreach (frame[j]) begin
                    crc = crcUpdate(crc, frame[j]);
                    expQ.push_back({1'b0, frame[j]});
                end
                crc = ~crc;
                for (int k = 0; k < 4; k++) expQ.push_back({(k == 3), crc[8*k +: 8]});
                frame.delete();
            end
        end
    endtask

    // Drive the stimulus stream until nFrames final FCS bytes have been seen.
    //   rndIn / rndOut : randomly drop in_valid / out_ready on some cycles
    //   abortAfter     : when that many output bytes have transferred, pulse
    //                    clear (or reset, if useReset) instead and stop
    //                    (-1 = never abort)
    //   cycles         : number of clock cycles the run took
    task automatic applyStimulus(input bit rndIn, input bit rndOut, input int nFrames,
                                 input int abortAfter, input bit useReset,
                                 output int cycles);
        int idx;
        bit aborted;
        idx = 0;
        cycles = 0;
        aborted = 1'b0;
        outQ.delete();
        inQ.delete();
        lastCount = 0;
        while (lastCount < nFrames && !aborted && cycles < 20000) begin
            @(posedge clk); #1;
            if (abortAfter >= 0 && outQ.size() == abortAfter) begin
                if (useReset) reset = 1'b1;
                else clear = 1'b1;
                in_valid  = 1'b0;
                out_ready = 1'b0;
                aborted   = 1'b1;
            end else begin
                if (idx < stimData.size()) begin
                    in_valid = rndIn ? ($urandom_range(0, 3) != 0) : 1'b1;
                    in_data  = stimData[idx];
                    in_last  = stimLast[idx];
                end else begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                    in_last  = 1'($urandom);
                end
                out_ready = rndOut ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            @(negedge clk); #1;
            if (in_valid && mInReady && !reset && !clear) idx++;
            cycles++;
        end
        @(posedge clk); #1;
        reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        if (!aborted) checkOutput("frameDone", 32'(lastCount >= nFrames), 32'd1);
    endtask

    // Compare the collected output and the accepted input against the model.
    task automatic compareRun(input int minLen, input string tag, input bit prefixOnly);
        int n;
        buildExpected(minLen);
        if (!prefixOnly) checkOutput({tag, ".outLen"}, 32'(outQ.size()), 32'(expQ.size()));
        n = (outQ.size() < expQ.size()) ? outQ.size() : expQ.size();
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("%s.out[%0d]", tag, i), 32'(outQ[i]), 32'(expQ[i]));
        checkOutput({tag, ".inLen"}, 32'(inQ.size()), 32'(stimData.size()));
        n = (inQ.size() < stimData.size()) ? inQ.size() : stimData.size();
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("%s.in[%0d]", tag, i), 32'(inQ[i]), 32'(stimData[i]));
    endtask

    // Receiver-side check: running the CRC over payload, pad and FCS together
    // must leave the fixed Ethernet residue in the register.
    task automatic checkResidue(input string tag);
        logic [31:0] crc;
        crc = 32'hFFFFFFFF;
        foreach (outQ[i]) crc = crcUpdate(crc, outQ[i][7:0]);
        checkOutput({tag, ".residue"}, crc, 32'hDEBB20E3);
    endtask

    // After an abort, nothing from the dropped frame may appear on the output.
    task automatic checkQuiet(input string tag);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput($sformatf("%s.quiet[%0d]", tag, i), 32'(mOutValid), 32'd0);
        end
    endtask

    // Main test sequence.
    initial begin
        int          cyc;
        logic [31:0] c;
        logic [7:0]  refBytes[13];
        int          n;

        // Fill the CRC lookup table, one bit at a time per entry.
        for (int i = 0; i < 256; i++) begin
            c = 32'(i);
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crcTable[i] = c;
        end

        // Reset state: the input is wired straight through to the output.
        sel = 1'b1;
        applyReset();
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 8'hA5; in_last = 1'b0; out_ready = 1'b0;
        #1;
        checkOutput("rst.outValid", 32'(mOutValid), 32'd1);
        checkOutput("rst.inReady0", 32'(mInReady), 32'd0);
        checkOutput("rst.outLast", 32'(mOutLast), 32'd0);
        checkOutput("rst.outData", 32'(mOutData), 32'hA5);
        out_ready = 1'b1;
        #1;
        checkOutput("rst.inReady1", 32'(mInReady), 32'd1);
        in_valid = 1'b0;
        #1;
        checkOutput("rst.outValid0", 32'(mOutValid), 32'd0);

        // Known CRC-32 check value with no padding ("123456789").
        sel = 1'b0;
        applyReset();
        stimData.delete(); stimLast.delete();
        for (int i = 0; i < 9; i++) begin
            stimData.push_back(8'h31 + 8'(i));
            stimLast.push_back(i == 8);
        end
        refBytes = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                     8'h26, 8'h39, 8'hF4, 8'hCB};
        applyStimulus(1'b0, 1'b0, 1, -1, 1'b0, cyc);
        checkOutput("ascii.len", 32'(outQ.size()), 32'd13);
        n = (outQ.size() < 13) ? outQ.size() : 13;
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("ascii[%0d]", i), 32'(outQ[i]), {23'd0, (i == 12), refBytes[i]});
        compareRun(0, "ascii", 1'b0);

        // Random frames with no padding and random handshakes.
        applyReset();
        stimData.delete(); stimLast.delete();
        for (int f = 0; f < 3; f++) addRandomFrame($urandom_range(1, 30));
        applyStimulus(1'b1, 1'b1, 3, -1, 1'b0, cyc);
        compareRun(0, "rawRand", 1'b0);

        // 14-byte frame: padded out to 60 bytes, 64 output transfers in total.
        sel = 1'b1;
        applyReset();
        stimData.delete(); stimLast.delete();
        addRandomFrame(14);
        applyStimulus(1'b0, 1'b0, 1, -1, 1'b0, cyc);
        checkOutput("short.xfers", 32'(outQ.size()), 32'd64);
        compareRun(60, "short", 1'b0);
        checkResidue("short");

        // Frames of exactly 60 and 1500 bytes need no pad.
        applyReset();
        stimData.delete(); stimLast.delete();
        addRandomFrame(60);
        applyStimulus(1'b0, 1'b0, 1, -1, 1'b0, cyc);
        compareRun(60, "len60", 1'b0);
        checkResidue("len60");

        applyReset();
        stimData.delete(); stimLast.delete();
        addRandomFrame(1500);
        applyStimulus(1'b0, 1'b0, 1, -1, 1'b0, cyc);
        compareRun(60, "len1500", 1'b0);
        checkResidue("len1500");

        // 20-byte frames with in_valid and out_ready toggling at random.
        for (int r = 0; r < 3; r++) begin
            applyReset();
            stimData.delete(); stimLast.delete();
            addRandomFrame(20);
            applyStimulus(1'b1, 1'b1, 1, -1, 1'b0, cyc);
            compareRun(60, $sformatf("tog%0d", r), 1'b0);
        end

        // Mixed-length back-to-back frames with random handshakes.
        applyReset();
        stimData.delete(); stimLast.delete();
        for (int f = 0; f < 4; f++) addRandomFrame($urandom_range(1, 80));
        applyStimulus(1'b1, 1'b1, 4, -1, 1'b0, cyc);
        compareRun(60, "stream", 1'b0);

        // Two back-to-back 1-byte frames: 128 output bytes with no dead cycle.
        applyReset();
        stimData.delete(); stimLast.delete();
        addRandomFrame(1);
        addRandomFrame(1);
        applyStimulus(1'b0, 1'b0, 2, -1, 1'b0, cyc);
        checkOutput("b2b.cycles", 32'(cyc), 32'd128);
        compareRun(60, "b2b", 1'b0);

        // Pulse clear during FCS byte index 1, then send a clean 64-byte frame.
        applyReset();
        stimData.delete(); stimLast.delete();
        addRandomFrame(64);
        applyStimulus(1'b0, 1'b0, 1, 65, 1'b0, cyc);
        checkOutput("clr.lastSeen", 32'(lastCount), 32'd0);
        checkOutput("clr.outLen", 32'(outQ.size()), 32'd65);
        compareRun(60, "clr", 1'b1);
        checkQuiet("clr");
        stimData.delete(); stimLast.delete();
        addRandomFrame(64);
        applyStimulus(1'b0, 1'b0, 1, -1, 1'b0, cyc);
        compareRun(60, "clrNext", 1'b0);

        // Pulse reset during PAD, then send a 14-byte frame.
        stimData.delete(); stimLast.delete();
        addRandomFrame(5);
        applyStimulus(1'b0, 1'b0, 1, 20, 1'b1, cyc);
        checkOutput("rstPad.lastSeen", 32'(lastCount), 32'd0);
        checkOutput("rstPad.outLen", 32'(outQ.size()), 32'd20);
        compareRun(60, "rstPad", 1'b1);
        checkQuiet("rstPad");
        stimData.delete(); stimLast.delete();
        addRandomFrame(14);
        applyStimulus(1'b1, 1'b1, 1, -1, 1'b0, cyc);
        compareRun(60, "rstNext", 1'b0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/tx_fcs_append.md
TX_FCS_APPEND -- requirements
Module: tx_fcs_append

Interface
- REQ-001: Parameter MIN_LEN, default 60, minimum frame length in bytes, excluding FCS; 0 disables padding.
- REQ-002: Parameter CNT_W, default 16, width of the internal byte counter.
- REQ-003: clk  input  1  sole clock; all logic on its rising edge.
- REQ-004: reset  input  1  synchronous, active-high reset.
- REQ-005: clear  input  1  synchronous abort of the current frame, same effect as reset.
- REQ-006: in_data  input  8  frame byte, destination-MAC first, no FCS.
- REQ-007: in_valid  input  1  in_data holds a valid byte.
- REQ-008: in_last  input  1  qualifies the final byte of a frame; sampled with in_valid.
- REQ-009: in_ready  output  1  block accepts an in_data byte this cycle.
- REQ-010: out_data  output  8  outgoing byte: payload, pad or FCS.
- REQ-011: out_valid  output  1  out_data holds a valid byte.
- REQ-012: out_last  output  1  asserted with the final FCS byte only.
- REQ-013: out_ready  input  1  downstream accepts out_data this cycle.

Function
- REQ-014: A byte transfers on either port only in a cycle where its valid and ready are both high.
- REQ-015: The state machine SHALL have four states: IDLE, DATA, PAD and FCS, with FCS byte index 0..3.
- REQ-016: In IDLE and DATA, out_data=in_data, out_valid=in_valid, in_ready=out_ready and out_last=0; the path is combinational with zero latency.
- REQ-017: IDLE goes to DATA on the first input transfer, unless that transfer also has in_last.
- REQ-018: A transfer with in_last goes to PAD if the byte count after that byte is below MIN_LEN, else to FCS index 0.
- REQ-019: In PAD and FCS, in_ready=0, out_valid=1 and input is ignored.
- REQ-020: In PAD, out_data=0x00; one pad byte per output transfer until the total count equals MIN_LEN, then go to FCS index 0.
- REQ-021: In FCS, out_data=FCS byte[index]; index advances per output transfer; the transfer at index 3 asserts out_last and returns to IDLE.
- REQ-022: The byte counter SHALL count every output transfer of payload or pad, reset to 0 on return to IDLE, and saturate at 2^CNT_W-1 without wrapping.
- REQ-023: The CRC SHALL be Ethernet CRC-32: reflected polynomial 0xEDB88320, register initialised to 0xFFFFFFFF at IDLE, updated LSB-first with each payload and pad byte as it transfers out.
- REQ-024: FCS = bitwise NOT of the CRC register, frozen on entry to FCS; it is sent least-significant byte first, as bytes [7:0], [15:8], [23:16], [31:24].
- REQ-025: With out_ready low, every output SHALL hold its value and no state, counter or CRC change occurs.
- REQ-026: A one-byte frame, with in_valid and in_last on the first byte, SHALL be handled like any other: pad or FCS follows directly.
- REQ-027: Back-to-back frames are allowed: IDLE accepts a new first byte in the cycle after the final FCS transfer, with no dead cycle beyond that.

Reset
- REQ-028: On reset or clear: state=IDLE, counter=0, CRC register=0xFFFFFFFF, FCS index=0, so that out_valid=in_valid, out_last=0 and in_ready=out_ready.
- REQ-029: Reset or clear mid-frame, in any state, SHALL drop the partial frame without emitting pad or FCS; the next input byte starts a new frame.
- REQ-030: Reset and clear take priority over any simultaneous transfer.

Verification
- REQ-031: MIN_LEN=0, input ASCII "123456789" with last on '9', out_ready=1 -> output is the 9 bytes, then 0x26 0x39 0xF4 0xCB, with out_last on 0xCB.
- REQ-032: MIN_LEN=60, 14-byte frame -> 14 payload bytes, 46 bytes of 0x00, 4 FCS bytes; 64 output transfers; the FCS matches a software CRC over 60 bytes.
- REQ-033: MIN_LEN=60, 60-byte and 1500-byte frames -> no pad, FCS follows immediately; a receiver CRC run over the frame plus FCS leaves residue 0xDEBB20E3 in reflected register form.
- REQ-034: Random out_ready and in_valid toggling on a 20-byte frame -> byte-identical output to the run with constant ready, and no byte dropped or duplicated.
- REQ-035: Assert clear during FCS index 1 -> no further out_valid from that frame; a following 64-byte frame is emitted with a correct FCS.
- REQ-036: Two back-to-back 1-byte frames, MIN_LEN=60 -> two 64-byte outputs, each with out_last on its final FCS byte only.
